// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit controller: opcodes,
// datapath unit selects and FSM states.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] SEL_MULT  = 2'd0;
    localparam logic [1:0] SEL_MULTU = 2'd1;
    localparam logic [1:0] SEL_DIV   = 2'd2;
    localparam logic [1:0] SEL_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2
    } state_e;

    // Unit select is the low two opcode bits for ops 0-3.
    function automatic logic [1:0] op_to_sel(input logic [2:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue handshake, datapath and result bundle of the MDU controller.
// slave = controller side, master = issuer/datapath side.
interface mdu_if #(
    parameter int WIDTH = 32
) ();
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               flush;
    logic [WIDTH-1:0]   dp_a;
    logic [WIDTH-1:0]   dp_b;
    logic [1:0]         dp_sel;
    logic [2*WIDTH-1:0] dp_p;
    logic [WIDTH-1:0]   dp_q;
    logic [WIDTH-1:0]   dp_r;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               done;
    logic               dz;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, dp_p, dp_q, dp_r,
        output req_ready, dp_a, dp_b, dp_sel, hi, lo, busy, done, dz
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush, dp_p, dp_q, dp_r,
        input  req_ready, dp_a, dp_b, dp_sel, hi, lo, busy, done, dz
    );
endinterface

// File: rtl/mdu_lat_cnt.sv
// Latency counter: cleared on issue, counts while enabled, flags the
// cycle on which the count reaches the terminal value.
module mdu_lat_cnt #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [CW-1:0] i_tc,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = i_en && (r_cnt == i_tc);

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: issues ops to an external mul/div datapath, waits a fixed
// latency and captures HI/LO. Optional abort via macro MDU_FLUSH_EN.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 36
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam logic [CW-1:0] MUL_TC = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_TC = CW'(DIV_LAT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_dp_a;
    logic [WIDTH-1:0] r_dp_b;
    logic [1:0]       r_dp_sel;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dz;

    logic             w_flush;
    logic             w_start;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_finish;
    logic             w_abort;
    logic             w_tc_hit;
    logic             w_wait;
    logic [CW-1:0]    w_tc;

`ifdef MDU_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_wait = (r_state != S_IDLE);
    assign w_tc   = (r_state == S_DIV_WAIT) ? DIV_TC : MUL_TC;

    mdu_lat_cnt #(.CW(CW)) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start | w_abort),
        .i_en   (w_wait),
        .i_tc   (w_tc),
        .o_done (w_tc_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_MULT, OP_MULTU: begin
                            w_start     = 1'b1;
                            w_state_nxt = S_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_start     = 1'b1;
                            w_state_nxt = S_DIV_WAIT;
                        end
                        OP_MTHI: w_mthi = 1'b1;
                        OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL_WAIT, S_DIV_WAIT: begin
                // An abort takes priority over the final-count edge.
                if (w_flush) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tc_hit) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_a   <= '0;
            r_dp_b   <= '0;
            r_dp_sel <= SEL_MULT;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            if (w_start) begin
                r_dp_a   <= bus.req_a;
                r_dp_b   <= bus.req_b;
                r_dp_sel <= op_to_sel(bus.req_op);
            end
            if (w_mthi) begin
                r_hi   <= bus.req_a;
                r_done <= 1'b1;
            end
            if (w_mtlo) begin
                r_lo   <= bus.req_a;
                r_done <= 1'b1;
            end
            if (w_finish) begin
                r_done <= 1'b1;
                if (r_state == S_MUL_WAIT) begin
                    r_hi <= bus.dp_p[2*WIDTH-1:WIDTH];
                    r_lo <= bus.dp_p[WIDTH-1:0];
                end else if (r_dp_b == '0) begin
                    // Divide by zero keeps the architectural HI/LO intact.
                    r_dz <= 1'b1;
                end else begin
                    r_hi <= bus.dp_r;
                    r_lo <= bus.dp_q;
                end
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = w_wait;
    assign bus.dp_a      = r_dp_a;
    assign bus.dp_b      = r_dp_b;
    assign bus.dp_sel    = r_dp_sel;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.done      = r_done;
    assign bus.dz        = r_dz;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 The block SHALL have parameter MUL_LAT, default 4: datapath multiply latency in cycles (>=1).
REQ-003 The block SHALL have parameter DIV_LAT, default 36: datapath divide latency in cycles (>=1).
REQ-004 The block SHALL have these ports: clk  in  1  sole clock; rising edge.
REQ-005 The block SHALL have these ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have these ports: req_valid in 1, req_ready out 1, req_op in 3, req_a in WIDTH, req_b in WIDTH: issue handshake, opcode and operands.
REQ-007 The block SHALL have these ports: flush  in  1  abort of the in-flight operation.
REQ-008 The block SHALL have these ports: dp_a out WIDTH, dp_b out WIDTH, dp_sel out 2: held operands and unit select (0 MULT, 1 MULTU, 2 DIV, 3 DIVU).
REQ-009 The block SHALL have these ports: dp_p in 2*WIDTH, dp_q in WIDTH, dp_r in WIDTH: product, quotient, remainder.
REQ-010 The block SHALL have these ports: hi out WIDTH, lo out WIDTH, busy out 1, done out 1, dz out 1.

Function
REQ-011 Opcodes SHALL be: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP.
REQ-012 FSM states SHALL be IDLE, MUL_WAIT, DIV_WAIT; req_ready SHALL be 1 only in IDLE.
REQ-013 A request SHALL be accepted on a rising edge with req_valid and req_ready both 1.
REQ-014 On acceptance of ops 0-3: latch req_a/req_b into dp_a/dp_b, set dp_sel, clear counter, enter MUL_WAIT (ops 0-1) or DIV_WAIT (ops 2-3).
REQ-015 dp_a, dp_b, dp_sel SHALL hold stable from acceptance until the state returns to IDLE.
REQ-016 The counter SHALL increment each cycle in a WAIT state; on the edge where it equals LAT-1, capture results and return to IDLE.
REQ-017 Result visibility: hi/lo updated MUL_LAT (or DIV_LAT) cycles after the accept edge; done pulses high 1 cycle coincident with the update.
REQ-018 Multiply capture: hi = dp_p[2W-1:W], lo = dp_p[W-1:0].
REQ-019 Divide capture: lo = dp_q, hi = dp_r.
REQ-020 Divide with dp_b == 0 SHALL leave hi/lo unchanged and pulse dz together with done.
REQ-021 MTHI/MTLO SHALL write req_a to hi/lo on the accept edge, stay in IDLE, and pulse done next cycle; NOP accepted with no effect and no done.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 Back-to-back: a request may be accepted on the cycle after the completing edge (IDLE, ready=1).
REQ-024 flush with state IDLE SHALL have no effect and SHALL not block acceptance of a simultaneous request.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, counter 0, hi=0, lo=0, dp_a=0, dp_b=0, dp_sel=0, done=0, dz=0.
REQ-026 Reset mid-operation SHALL discard the operation; no done is produced after release.

Configuration
REQ-027 With MDU_FLUSH_EN defined: flush high in a WAIT state returns to IDLE next edge with no hi/lo write and no done; flush wins over the final-count edge.
REQ-028 Without MDU_FLUSH_EN: the flush port SHALL exist but be ignored; operations always complete.

Structure
REQ-029 Opcode constants, dp_sel encodings and state encoding SHALL live in shared package mdu_pkg.
REQ-030 The latency counter SHALL be a sub-module mdu_lat_cnt (clear, enable, terminal-count input, done output).
REQ-031 The multiplier and divider datapath SHALL remain outside this block.

Verification
REQ-032 MULT a=0xFFFFFFFE(-2), b=3, dp_p=0xFFFFFFFF_FFFFFFFA -> after 4 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle.
REQ-033 DIVU a=7, b=2, dp_q=3, dp_r=1 -> after 36 cycles lo=3, hi=1; req_ready=0, busy=1 throughout wait.
REQ-034 DIV b=0 with hi=0x11, lo=0x22 -> hi/lo unchanged, dz=1 and done=1 same cycle.
REQ-035 MTHI a=0xDEADBEEF then MTLO a=0x1234 on consecutive cycles -> hi=0xDEADBEEF, lo=0x1234, two done pulses.
REQ-036 MULTU issued, flush at cycle 2 (MDU_FLUSH_EN) -> IDLE, no done, hi/lo unchanged; same without macro -> completes normally.
REQ-037 rst_n low at cycle 10 of a DIV -> all outputs 0 immediately; no done after release.
